adc_capture: RTL and testbench

- Multi-channel successor to the single-register ADC probe.
- Registers N_CH signed fixed-point analog-model signals plus the emulator time stamp every clk, and requantises them to an ADC output format (floor plus saturation).
- Decimates and captures an armed burst of samples into an on-chip FIFO, read out via valid/ready.
- Sits beside the channel/CTLE model outputs as the emulation-side data logger.

---
 rtl/adc_capture.sv | 197 +++++++++++++++++++
 tb/tb_adc_capture.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// Multi-channel ADC probe: quantising pipeline, armed decimated burst capture, show-ahead FIFO.
// Define ADC_TRIG_EN to start capture on a rising crossing of channel 0 through trig_level.
module adc_capture #(
    parameter int N_CH       = 1,
    parameter int SIG_BITS   = 16,
    parameter int SIG_POINT  = 12,
    parameter int OUT_BITS   = 8,
    parameter int OUT_POINT  = 4,
    parameter int TIME_BITS  = 32,
    parameter int DEPTH      = 16,
    parameter int DECIM_BITS = 8,
    parameter int CNT_BITS   = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [TIME_BITS-1:0]     time_curr,
    input  logic [N_CH*SIG_BITS-1:0] sig,
    input  logic                     arm,
    input  logic [DECIM_BITS-1:0]    decim,
    input  logic [CNT_BITS-1:0]      num_samples,
    input  logic [OUT_BITS-1:0]      trig_level,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [TIME_BITS-1:0]     rd_time,
    output logic [N_CH*OUT_BITS-1:0] rd_data,
    output logic [CNT_BITS-1:0]      level
);
    localparam int SHIFT = SIG_POINT - OUT_POINT;
    localparam int PW    = $clog2(DEPTH);
    localparam int EW    = TIME_BITS + N_CH * OUT_BITS;
    localparam logic signed [SIG_BITS-1:0] QMAX = SIG_BITS'((1 << (OUT_BITS - 1)) - 1);
    localparam logic signed [SIG_BITS-1:0] QMIN = ~QMAX;

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t state, state_n;

    (* dont_touch = "true" *) logic [TIME_BITS-1:0]     t1;
    (* dont_touch = "true" *) logic [N_CH*SIG_BITS-1:0] s1;

    logic [TIME_BITS-1:0]     t2;
    logic [N_CH*OUT_BITS-1:0] q, q2;
    logic signed [SIG_BITS-1:0] sh;

    logic [CNT_BITS-1:0]   cnt, cnt_n, cnt_inc;
    logic [DECIM_BITS-1:0] dcnt, dcnt_n;
    logic                  ovf_n, wr, pop, full, accept;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // Floor via arithmetic shift, then clamp into the output range
    always_comb begin
        q  = '0;
        sh = '0;
        for (int c = 0; c < N_CH; c++) begin
            sh = $signed(s1[c*SIG_BITS +: SIG_BITS]) >>> SHIFT;
            if (sh > QMAX)
                q[c*OUT_BITS +: OUT_BITS] = {1'b0, {(OUT_BITS-1){1'b1}}};
            else if (sh < QMIN)
                q[c*OUT_BITS +: OUT_BITS] = {1'b1, {(OUT_BITS-1){1'b0}}};
            else
                q[c*OUT_BITS +: OUT_BITS] = sh[OUT_BITS-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t1 <= '0;
            s1 <= '0;
            t2 <= '0;
            q2 <= '0;
        end else begin
            t1 <= time_curr;
            s1 <= sig;
            t2 <= t1;
            q2 <= q;
        end
    end

`ifdef ADC_TRIG_EN
    logic [OUT_BITS-1:0] prev_q;
    logic                prev_ok;
    logic                trig;

    assign trig = prev_ok
               && ($signed(prev_q) < $signed(trig_level))
               && ($signed(q2[OUT_BITS-1:0]) >= $signed(trig_level));

    // prev_ok drops on arm so a level already above threshold cannot fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            prev_ok <= 1'b0;
        end else begin
            prev_q  <= q2[OUT_BITS-1:0];
            prev_ok <= !(arm && (state == IDLE || state == DONE));
        end
    end
`else
    logic unused_trig;
    assign unused_trig = ^trig_level;
`endif

    assign cnt_inc = cnt + CNT_BITS'(1);
    assign full    = (level == CNT_BITS'(DEPTH));
    assign pop     = rd_valid && rd_ready;
    assign accept  = wr && (!full || pop);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dcnt_n  = dcnt;
        ovf_n   = overflow;
        wr      = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (arm) begin
                    state_n = ARMED;
                    cnt_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            ARMED: begin
                dcnt_n = '0;
`ifdef ADC_TRIG_EN
                if (num_samples == '0) begin
                    state_n = DONE;
                end else if (trig) begin
                    wr      = 1'b1;
                    cnt_n   = cnt_inc;
                    dcnt_n  = (decim == '0) ? '0 : DECIM_BITS'(1);
                    state_n = (cnt_inc == num_samples) ? DONE : CAPTURE;
                end
`else
                state_n = (num_samples == '0) ? DONE : CAPTURE;
`endif
            end
            CAPTURE: begin
                dcnt_n = (dcnt == decim) ? '0 : dcnt + DECIM_BITS'(1);
                if (dcnt == '0) begin
                    wr    = 1'b1;
                    cnt_n = cnt_inc;
                    if (cnt_inc == num_samples)
                        state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (wr && full && !pop)
            ovf_n = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dcnt     <= dcnt_n;
            overflow <= ovf_n;
        end
    end

    assign busy = (state == ARMED) || (state == CAPTURE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= {t2, q2};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            level <= level + CNT_BITS'(accept) - CNT_BITS'(pop);
        end
    end

    // Memory is not reset, so the head is masked while empty
    assign rd_valid          = (level != '0);
    assign {rd_time, rd_data} = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: quantiser, decimation, overflow, reset, optional trigger.
module tb_adc_capture;
    localparam int N_CH = 2;
    localparam int SIG_BITS = 16;
    localparam int SIG_POINT = 12;
    localparam int OUT_BITS = 8;
    localparam int OUT_POINT = 6;
    localparam int TIME_BITS = 32;
    localparam int DEPTH = 4;
    localparam int DECIM_BITS = 8;
    localparam int CNT_BITS = 3;

    logic                     clk;
    logic                     rst_n;
    logic [TIME_BITS-1:0]     time_curr;
    logic [N_CH*SIG_BITS-1:0] sig;
    logic                     arm;
    logic [DECIM_BITS-1:0]    decim;
    logic [CNT_BITS-1:0]      num_samples;
    logic [OUT_BITS-1:0]      trig_level;
    logic                     busy, done, overflow, rd_valid, rd_ready;
    logic [TIME_BITS-1:0]     rd_time;
    logic [N_CH*OUT_BITS-1:0] rd_data;
    logic [CNT_BITS-1:0]      level;

    int total = 0;
    int bad = 0;
    logic [31:0] tcnt;
    logic [31:0] t0;
    logic [31:0] tt [3];
    int n;

    adc_capture #(
        .N_CH(N_CH), .SIG_BITS(SIG_BITS), .SIG_POINT(SIG_POINT),
        .OUT_BITS(OUT_BITS), .OUT_POINT(OUT_POINT), .TIME_BITS(TIME_BITS),
        .DEPTH(DEPTH), .DECIM_BITS(DECIM_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .time_curr(time_curr), .sig(sig),
        .arm(arm), .decim(decim), .num_samples(num_samples),
        .trig_level(trig_level), .busy(busy), .done(done),
        .overflow(overflow), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_time(rd_time), .rd_data(rd_data), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tcnt = tcnt + 1;
        time_curr = tcnt;
    endtask

    task automatic wait_done(input int lim);
        for (int k = 0; k < lim && !done; k++)
            tick();
        check("done_wait", 64'(done), 64'd1);
    endtask

    task automatic do_arm();
        t0 = time_curr;
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [15:0] d,
                             input logic [31:0] t);
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check({tag, "_data"}, 64'(rd_data), 64'(d));
        check({tag, "_time"}, 64'(rd_time), 64'(t));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ovf"}, 64'(overflow), 64'd0);
        check({tag, "_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_time"}, 64'(rd_time), 64'd0);
        check({tag, "_data"}, 64'(rd_data), 64'd0);
        check({tag, "_level"}, 64'(level), 64'd0);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        arm = 1'b0;
        rd_ready = 1'b0;
        decim = '0;
        num_samples = '0;
        trig_level = '0;
        sig = '0;
        tcnt = 32'd100;
        time_curr = tcnt;
        repeat (3) tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

`ifndef ADC_TRIG_EN
        // ch0 6.5 -> 6, ch1 -5.5 -> -6
        sig = {16'hFEA0, 16'h01A0};
        num_samples = 3'd4;
        decim = '0;
        repeat (3) tick();
        do_arm();
        check("t1_busy", 64'(busy), 64'd1);
        wait_done(20);
        check("t1_level", 64'(level), 64'd4);
        check("t1_ovf", 64'(overflow), 64'd0);
        check("t1_busy_end", 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++)
            pop_check("t1", 16'hFA06, t0 + 32'(i));
        check("t1_empty", 64'(rd_valid), 64'd0);

        // decimation by 3, streaming readout
        decim = 8'd2;
        num_samples = 3'd3;
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) tt[i] = '1;
        n = 0;
        do_arm();
        for (int k = 0; k < 30 && !(done && !rd_valid); k++) begin
            if (rd_valid) begin
                if (n < 3) tt[n] = rd_time;
                n++;
            end
            tick();
        end
        rd_ready = 1'b0;
        check("t3_count", 64'(n), 64'd3);
        for (int i = 0; i < 3; i++)
            check("t3_time", 64'(tt[i]), 64'(t0 + 32'(3 * i)));
        check("t3_done", 64'(done), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);

        // overflow: 6 samples into 4 entries
        decim = '0;
        num_samples = 3'd6;
        do_arm();
        wait_done(20);
        check("t4_level", 64'(level), 64'd4);
        check("t4_ovf", 64'(overflow), 64'd1);
        check("t4_head", 64'(rd_time), 64'(t0));
        n = 0;
        rd_ready = 1'b1;
        repeat (8) begin
            if (rd_valid) n++;
            tick();
        end
        rd_ready = 1'b0;
        check("t4_drained", 64'(n), 64'd4);
        check("t4_level0", 64'(level), 64'd0);

        // saturation; new arm clears overflow
        sig = {16'h8000, 16'h7FFF};
        num_samples = 3'd1;
        repeat (3) tick();
        do_arm();
        check("t2_ovf_clr", 64'(overflow), 64'd0);
        check("t2_done_clr", 64'(done), 64'd0);
        wait_done(20);
        pop_check("t2", 16'h807F, t0);

        // reset mid-burst with 3 entries buffered
        sig = {16'hFEA0, 16'h01A0};
        num_samples = 3'd6;
        do_arm();
        repeat (4) tick();
        check("t6_level3", 64'(level), 64'd3);
        check("t6_busy", 64'(busy), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("t6_rst");
        tick();
        rst_n = 1'b1;
        tick();
        num_samples = '0;
        do_arm();
        check("t6_done0", 64'(done), 64'd0);
        tick();
        check("t6_done1", 64'(done), 64'd1);
        check("t6_level", 64'(level), 64'd0);
`else
        trig_level = 8'd10;
        decim = '0;
        num_samples = 3'd4;
        sig = {16'h0000, 16'(15 * 64)};
        repeat (3) tick();
        do_arm();
        repeat (5) tick();
        check("tr_hold_busy", 64'(busy), 64'd1);
        check("tr_hold_level", 64'(level), 64'd0);
        sig = {16'h0000, 16'(5 * 64)};
        repeat (4) tick();
        check("tr_dip_level", 64'(level), 64'd0);
        for (int v = 0; v <= 20; v++) begin
            sig = {16'h0000, 16'(v * 64)};
            tick();
        end
        wait_done(20);
        check("tr_level", 64'(level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("tr_data", 64'(rd_data), 64'(16'(10 + i)));
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check("tr_empty", 64'(rd_valid), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
